// File: rtl/pl_run_ctrl.sv
// pl_run_ctrl: run/halt/single-step sequencer with key debounce, PC breakpoint and enabled-cycle counter.
module pl_run_ctrl #(
    parameter logic [15:0] DB_CYCLES    = 16'd50000,
    parameter logic [7:0]  RST_HOLD     = 8'd8,
    parameter logic        START_HALTED = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        key_run,
    input  logic        key_step,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic        cpu_resetn,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt
);
    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_HALT = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_STEP = 2'b11;
    localparam logic [15:0] DB_LAST   = DB_CYCLES - 16'd1;
    localparam logic [7:0]  HOLD_LAST = RST_HOLD - 8'd1;

    logic [1:0]  r_sync1, r_sync2, r_lvl;
    logic [15:0] r_db_cnt [2];
    logic [1:0]  r_state;
    logic [7:0]  r_hold_cnt;
    logic        r_cpu_resetn, r_bp_skip;
    logic [31:0] r_cycle_cnt;
    logic [1:0]  w_keys, w_press;
    logic        w_run_p, w_step_p, w_bp_hit, w_cpu_en;

    assign w_keys = {key_step, key_run};
    // Press fires in the cycle the accepted level is about to fall to 0.
    assign w_press[0] = ~r_sync2[0] & r_lvl[0] & (r_db_cnt[0] == DB_LAST);
    assign w_press[1] = ~r_sync2[1] & r_lvl[1] & (r_db_cnt[1] == DB_LAST);
    assign w_run_p  = w_press[0];
    assign w_step_p = w_press[1];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1     <= 2'b11;
            r_sync2     <= 2'b11;
            r_lvl       <= 2'b11;
            r_db_cnt[0] <= 16'd0;
            r_db_cnt[1] <= 16'd0;
        end else begin
            r_sync1 <= w_keys;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_lvl[k]) begin
                    r_db_cnt[k] <= 16'd0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_lvl[k]    <= r_sync2[k];
                    r_db_cnt[k] <= 16'd0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign w_bp_hit = bp_en & (pc == bp_addr) & ~r_bp_skip;
    assign w_cpu_en = (r_state == S_STEP) | ((r_state == S_RUN) & ~w_bp_hit);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_HOLD;
            r_hold_cnt   <= 8'd0;
            r_cpu_resetn <= 1'b0;
            r_bp_skip    <= 1'b0;
            r_cycle_cnt  <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + {31'd0, w_cpu_en};
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_cpu_resetn <= 1'b1;
                        r_state      <= START_HALTED ? S_HALT : S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                S_HALT: begin
                    if (w_run_p) begin
                        r_state   <= S_RUN;
                        r_bp_skip <= 1'b1;
                    end else if (w_step_p) begin
                        r_state <= S_STEP;
                    end
                end
                S_STEP: r_state <= S_HALT;
                default: begin
                    // Skip only guards the resume cycle(s) still sitting on the breakpoint.
                    if (pc != bp_addr) r_bp_skip <= 1'b0;
                    if (w_run_p || w_bp_hit) r_state <= S_HALT;
                end
            endcase
        end
    end

    assign cpu_en     = w_cpu_en;
    assign cpu_resetn = r_cpu_resetn;
    assign halted     = (r_state == S_HALT);
    assign state      = r_state;
    assign cycle_cnt  = r_cycle_cnt;
endmodule

// File: tb/tb_pl_run_ctrl.sv
// tb_pl_run_ctrl: scenario bench for pl_run_ctrl; every enabled cycle is matched against a queue of expected cycle_cnt values.
module tb_pl_run_ctrl;
    logic        clock = 1'b0;
    logic        resetn;
    logic        key_run, key_step, bp_en;
    logic [31:0] bp_addr, pc;
    logic        cpu_en, cpu_resetn, halted;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb [$];

    pl_run_ctrl #(.DB_CYCLES(16'd4), .RST_HOLD(8'd8), .START_HALTED(1'b1)) dut (
        .clock(clock), .resetn(resetn), .key_run(key_run), .key_step(key_step),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
        .cpu_resetn(cpu_resetn), .halted(halted), .state(state), .cycle_cnt(cycle_cnt)
    );

    always #5 clock = ~clock;

    // Every enabled cycle must have been announced by the running scenario.
    always @(negedge clock) begin
        if (resetn === 1'b1 && cpu_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_en: cpu_en=1 cycle_cnt=%h, required no enable", cycle_cnt);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (cycle_cnt !== e) begin
                    n_bad++;
                    $display("FAIL sb_cycle_cnt: got %h, required %h", cycle_cnt, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int n;
        resetn = 1'b0; key_run = 1'b1; key_step = 1'b1;
        bp_en = 1'b0; bp_addr = 32'd0; pc = 32'd0;
        repeat (3) tick();
        n_cmp++;
        if ({state, cpu_resetn, halted, cpu_en, cycle_cnt} !== {2'b00, 1'b0, 1'b0, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_vals: st=%b rn=%b h=%b en=%b cnt=%h, required 00 0 0 0 0", state, cpu_resetn, halted, cpu_en, cycle_cnt);
        end
        resetn = 1'b1;
        n = 0;
        while (cpu_resetn !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 8) begin
            n_bad++;
            $display("FAIL reset_hold: cpu_resetn rose after %0d cycles, required 8", n);
        end
        n_cmp++;
        if ({state, halted, cpu_en, cycle_cnt} !== {2'b01, 1'b1, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL post_hold: st=%b h=%b en=%b cnt=%h, required 01 1 0 0", state, halted, cpu_en, cycle_cnt);
        end
    endtask

    task automatic test_step();
        int en_n, first;
        en_n = 0; first = -1;
        sb.push_back(32'd0);
        key_step = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (cpu_en === 1'b1) begin
                en_n++;
                first = i;
            end
        end
        key_step = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (en_n !== 1 || first !== 6) begin
            n_bad++;
            $display("FAIL step_pulse: %0d enables at cycle %0d, required 1 at cycle 6", en_n, first);
        end
        n_cmp++;
        if (cycle_cnt !== 32'd1 || state !== 2'b01) begin
            n_bad++;
            $display("FAIL step_after: cnt=%h st=%b, required 1 01", cycle_cnt, state);
        end
    endtask

    task automatic test_glitch();
        key_step = 1'b0;
        repeat (2) tick();
        key_step = 1'b1;
        repeat (12) tick();
        n_cmp++;
        if (cycle_cnt !== 32'd1 || state !== 2'b01) begin
            n_bad++;
            $display("FAIL glitch: cnt=%h st=%b, required 1 01", cycle_cnt, state);
        end
    endtask

    task automatic test_breakpoint();
        logic en;
        bit hit;
        en = 1'b0; hit = 0;
        bp_en = 1'b1; bp_addr = 32'h10; pc = 32'd0;
        for (int v = 1; v <= 4; v++) sb.push_back(32'(v));
        key_run = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (state === 2'b10 && pc === 32'h10) begin
                hit = 1;
                break;
            end
            en = cpu_en;
            @(posedge clock);
            #1;
            if (en) pc = pc + 32'd4;
        end
        n_cmp++;
        if (!hit || cpu_en !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hit_en: reached=%0d cpu_en=%b, required 1 0", hit, cpu_en);
        end
        @(negedge clock);
        n_cmp++;
        if (state !== 2'b01 || cycle_cnt !== 32'd5) begin
            n_bad++;
            $display("FAIL bp_halt: st=%b cnt=%h, required 01 5", state, cycle_cnt);
        end
        key_run = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_resume();
        bit ok;
        ok = 0;
        sb.push_back(32'd5); sb.push_back(32'd6); sb.push_back(32'd7);
        key_run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (state === 2'b10) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok || cpu_en !== 1'b1 || pc !== 32'h10) begin
            n_bad++;
            $display("FAIL resume_skip: run=%0d en=%b pc=%h, required 1 1 10", ok, cpu_en, pc);
        end
        @(posedge clock); #1; pc = 32'h14;
        @(negedge clock);
        n_cmp++;
        if (state !== 2'b10 || cpu_en !== 1'b1) begin
            n_bad++;
            $display("FAIL resume_run: st=%b en=%b, required 10 1", state, cpu_en);
        end
        @(posedge clock); #1; pc = 32'h18;
        @(posedge clock); #1; pc = 32'h10;
        @(negedge clock);
        n_cmp++;
        if (cpu_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rehit_en: cpu_en=%b, required 0", cpu_en);
        end
        @(negedge clock);
        n_cmp++;
        if (state !== 2'b01 || cycle_cnt !== 32'd8) begin
            n_bad++;
            $display("FAIL rehit_halt: st=%b cnt=%h, required 01 8", state, cycle_cnt);
        end
        key_run = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_run_wins();
        bit stepped, back;
        stepped = 0; back = 0;
        bp_en = 1'b0;
        for (int v = 8; v <= 27; v++) sb.push_back(32'(v));
        key_run = 1'b0; key_step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state === 2'b11) stepped = 1;
        end
        n_cmp++;
        if (stepped || state !== 2'b10) begin
            n_bad++;
            $display("FAIL run_wins: stepped=%0d st=%b, required 0 10", stepped, state);
        end
        key_run = 1'b1; key_step = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (state !== 2'b10) begin
            n_bad++;
            $display("FAIL release_no_pulse: st=%b, required 10", state);
        end
        key_run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state === 2'b01) begin
                back = 1;
                break;
            end
        end
        n_cmp++;
        if (!back || cycle_cnt !== 32'd28) begin
            n_bad++;
            $display("FAIL run_stop: halted=%0d cnt=%h, required 1 1c", back, cycle_cnt);
        end
        key_run = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_wrap_and_async_reset();
        bit ok;
        ok = 0;
        force dut.r_cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle_cnt;
        n_cmp++;
        if (cycle_cnt !== 32'hFFFF_FFFE) begin
            n_bad++;
            $display("FAIL preload: got %h, required fffffffe", cycle_cnt);
        end
        sb.push_back(32'hFFFF_FFFE); sb.push_back(32'hFFFF_FFFF); sb.push_back(32'h0);
        key_run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (state === 2'b10) begin
                ok = 1;
                break;
            end
        end
        @(negedge clock);
        @(negedge clock);
        @(posedge clock);
        #1;
        n_cmp++;
        if (!ok || cycle_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL wrap: run=%0d cnt=%h, required 1 1", ok, cycle_cnt);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_en, state, cpu_resetn, halted, cycle_cnt} !== {1'b0, 2'b00, 1'b0, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL async_reset: en=%b st=%b rn=%b h=%b cnt=%h, required 0 00 0 0 0", cpu_en, state, cpu_resetn, halted, cycle_cnt);
        end
        key_run = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expected enables never seen, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_breakpoint();
        test_resume();
        test_run_wins();
        test_wrap_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
